// File: rtl/finn_rtl_krnl_lane_alu.sv
// AXI4-Stream lane ALU: per-packet wrap add/sub, saturating add or pass on each lane,
// two pipeline stages feeding a credit-guarded FIFO with a registered output.
module finn_rtl_krnl_lane_alu #(
  parameter int unsigned C_AXIS_TDATA_WIDTH = 512,
  parameter int unsigned C_LANE_WIDTH       = 32,
  parameter int unsigned C_FIFO_DEPTH       = 16
) (
  input  logic                              s_axis_aclk,
  input  logic                              s_axis_aresetn,
  input  logic [C_LANE_WIDTH-1:0]           ctrl_constant,
  input  logic [1:0]                        ctrl_mode,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic                              s_axis_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                              m_axis_tlast,
  output logic [31:0]                       stat_pkt_count,
  output logic                              stat_sat_flag
);

  localparam int unsigned W  = C_AXIS_TDATA_WIDTH;
  localparam int unsigned KW = W / 8;
  localparam int unsigned LW = C_LANE_WIDTH;
  localparam int unsigned LB = LW / 8;
  localparam int unsigned NL = W / LW;
  localparam int unsigned EW = W + KW + 1;
  localparam int unsigned PW = $clog2(C_FIFO_DEPTH);
  localparam int unsigned CW = $clog2(C_FIFO_DEPTH + 1);

  logic          aresetn_q, aresetn_d;
  logic [CW-1:0] cr_q, cr_d;
  logic          first_q, first_d;
  logic [1:0]    op_mode_q, op_mode_d;
  logic [LW-1:0] op_k_q, op_k_d;

  logic          s1_valid_q, s1_valid_d;
  logic [W-1:0]  s1_data_q, s1_data_d;
  logic [KW-1:0] s1_keep_q, s1_keep_d;
  logic          s1_last_q, s1_last_d;
  logic [1:0]    s1_mode_q, s1_mode_d;
  logic [LW-1:0] s1_k_q, s1_k_d;

  logic          s2_valid_q, s2_valid_d;
  logic [W-1:0]  s2_data_q, s2_data_d;
  logic [KW-1:0] s2_keep_q, s2_keep_d;
  logic          s2_last_q, s2_last_d;

  logic [EW-1:0] mem [C_FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [EW-1:0] out_entry_q, out_entry_d;

  logic [31:0]   pkt_q, pkt_d;
  logic          sat_q, sat_d;

  logic          accept, emit, push, pop;
  logic [W-1:0]  lane_res;
  logic          sat_any;
  logic [LW-1:0] lane_x;
  logic [LW:0]   lane_sum;

  assign s_axis_tready  = aresetn_q && (cr_q < CW'(C_FIFO_DEPTH));
  assign accept         = s_axis_tvalid & s_axis_tready;
  assign emit           = out_valid_q & m_axis_tready;
  assign push           = s2_valid_q;
  // Reload the output register whenever it is empty or being drained this cycle.
  assign pop            = (!out_valid_q || emit) && (cnt_q != '0);

  assign m_axis_tvalid  = out_valid_q;
  assign m_axis_tdata   = out_entry_q[EW-1:KW+1];
  assign m_axis_tkeep   = out_entry_q[KW:1];
  assign m_axis_tlast   = out_entry_q[0];
  assign stat_pkt_count = pkt_q;
  assign stat_sat_flag  = sat_q;

  always_comb begin
    lane_res = s1_data_q;
    sat_any  = 1'b0;
    lane_x   = '0;
    lane_sum = '0;
    for (int i = 0; i < NL; i++) begin
      lane_x   = s1_data_q[i*LW +: LW];
      lane_sum = {1'b0, lane_x} + {1'b0, s1_k_q};
      // Lanes with no enabled bytes are forwarded untouched.
      if (s1_keep_q[i*LB +: LB] != '0) begin
        unique case (s1_mode_q)
          2'b00: lane_res[i*LW +: LW] = lane_sum[LW-1:0];
          2'b01: lane_res[i*LW +: LW] = lane_x - s1_k_q;
          2'b10: begin
            if (lane_sum[LW]) begin
              lane_res[i*LW +: LW] = '1;
              sat_any              = 1'b1;
            end else begin
              lane_res[i*LW +: LW] = lane_sum[LW-1:0];
            end
          end
          default: lane_res[i*LW +: LW] = lane_x;
        endcase
      end
    end
  end

  always_comb begin
    aresetn_d = 1'b1;
    cr_d      = cr_q + CW'(accept) - CW'(emit);

    first_d   = first_q;
    op_mode_d = op_mode_q;
    op_k_d    = op_k_q;
    if (accept) begin
      first_d = s_axis_tlast;
      if (first_q) begin
        op_mode_d = ctrl_mode;
        op_k_d    = ctrl_constant;
      end
    end

    s1_valid_d = accept;
    s1_data_d  = s_axis_tdata;
    s1_keep_d  = s_axis_tkeep;
    s1_last_d  = s_axis_tlast;
    s1_mode_d  = first_q ? ctrl_mode : op_mode_q;
    s1_k_d     = first_q ? ctrl_constant : op_k_q;

    s2_valid_d = s1_valid_q;
    s2_data_d  = lane_res;
    s2_keep_d  = s1_keep_q;
    s2_last_d  = s1_last_q;
    sat_d      = sat_q | (s1_valid_q & sat_any);

    wptr_d = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d = pop ? rptr_q + PW'(1) : rptr_q;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);

    out_valid_d = out_valid_q;
    out_entry_d = out_entry_q;
    if (pop) begin
      out_valid_d = 1'b1;
      out_entry_d = mem[rptr_q];
    end else if (emit) begin
      out_valid_d = 1'b0;
    end

    pkt_d = pkt_q + 32'(emit & out_entry_q[0]);
  end

  always_ff @(posedge s_axis_aclk) begin
    if (push) begin
      mem[wptr_q] <= {s2_data_q, s2_keep_q, s2_last_q};
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      aresetn_q   <= 1'b0;
      cr_q        <= '0;
      first_q     <= 1'b1;
      op_mode_q   <= '0;
      op_k_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_keep_q   <= '0;
      s1_last_q   <= 1'b0;
      s1_mode_q   <= '0;
      s1_k_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_keep_q   <= '0;
      s2_last_q   <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_entry_q <= '0;
      pkt_q       <= '0;
      sat_q       <= 1'b0;
    end else begin
      aresetn_q   <= aresetn_d;
      cr_q        <= cr_d;
      first_q     <= first_d;
      op_mode_q   <= op_mode_d;
      op_k_q      <= op_k_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_keep_q   <= s1_keep_d;
      s1_last_q   <= s1_last_d;
      s1_mode_q   <= s1_mode_d;
      s1_k_q      <= s1_k_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_keep_q   <= s2_keep_d;
      s2_last_q   <= s2_last_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_entry_q <= out_entry_d;
      pkt_q       <= pkt_d;
      sat_q       <= sat_d;
    end
  end

endmodule

// File: tb/tb_finn_rtl_krnl_lane_alu.sv
// Bench for finn_rtl_krnl_lane_alu: directed steps plus a random stream scored against
// a per-packet lane arithmetic model.
module tb_finn_rtl_krnl_lane_alu;

  localparam int unsigned W     = 64;
  localparam int unsigned LW    = 32;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [LW-1:0] ctrl_constant;
  logic [1:0]    ctrl_mode;
  logic          s_tvalid, s_tready, s_tlast;
  logic [W-1:0]  s_tdata;
  logic [7:0]    s_tkeep;
  logic          m_tvalid, m_tready, m_tlast;
  logic [W-1:0]  m_tdata;
  logic [7:0]    m_tkeep;
  logic [31:0]   pkt_count;
  logic          sat_flag;
  logic          m_tready_dir, rnd_ready_en, rnd_bit;

  int checks = 0;
  int errors = 0;

  logic [72:0] exp_q[$];
  logic [72:0] e, prev_out;
  logic [64:0] r;
  int          acc_cnt = 0, emit_cnt = 0, exp_pkts = 0, max_out = 0, stall_viol = 0;
  logic        exp_sat, m_first, prev_stall;
  logic [1:0]  m_mode;
  logic [31:0] m_k;
  logic [63:0] last_emit_data;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  assign m_tready = rnd_ready_en ? rnd_bit : m_tready_dir;

  finn_rtl_krnl_lane_alu #(
    .C_AXIS_TDATA_WIDTH(W),
    .C_LANE_WIDTH      (LW),
    .C_FIFO_DEPTH      (DEPTH)
  ) dut (
    .s_axis_aclk   (clk),
    .s_axis_aresetn(rst_n),
    .ctrl_constant (ctrl_constant),
    .ctrl_mode     (ctrl_mode),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast),
    .stat_pkt_count(pkt_count),
    .stat_sat_flag (sat_flag)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Returns {saturated, result} for one beat under a given op.
  function automatic logic [64:0] model(input logic [63:0] d, input logic [7:0] kp,
                                        input logic [1:0] md, input logic [31:0] k);
    logic [63:0]     o;
    logic            s;
    longint unsigned x, t;
    o = d;
    s = 1'b0;
    for (int i = 0; i < 2; i++) begin
      x = {32'b0, d[i*32 +: 32]};
      t = x;
      if (kp[i*4 +: 4] != 4'h0) begin
        case (md)
          2'd0: t = (x + k) & 64'hFFFF_FFFF;
          2'd1: t = (x + 64'h1_0000_0000 - k) & 64'hFFFF_FFFF;
          2'd2: begin
            t = x + k;
            if (t > 64'hFFFF_FFFF) begin
              t = 64'hFFFF_FFFF;
              s = 1'b1;
            end
          end
          default: t = x;
        endcase
      end
      o[i*32 +: 32] = t[31:0];
    end
    return {s, o};
  endfunction

  // Negedge values are what the next rising edge will transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_first    = 1'b1;
      exp_pkts   = 0;
      exp_sat    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_tvalid || {m_tdata, m_tkeep, m_tlast} !== prev_out)) stall_viol++;
      prev_stall = m_tvalid && !m_tready;
      prev_out   = {m_tdata, m_tkeep, m_tlast};
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("beat", {m_tdata, m_tkeep, m_tlast}, e);
          if (e[0]) exp_pkts++;
        end
        emit_cnt++;
        last_emit_data = m_tdata;
      end
      if (s_tvalid && s_tready) begin
        if (m_first) begin
          m_mode = ctrl_mode;
          m_k    = ctrl_constant;
        end
        r = model(s_tdata, s_tkeep, m_mode, m_k);
        exp_sat = exp_sat | r[64];
        exp_q.push_back({r[63:0], s_tkeep, s_tlast});
        m_first = s_tlast;
        acc_cnt++;
        if (exp_q.size() > max_out) max_out = exp_q.size();
      end
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic [7:0] kp, input logic l,
                           input logic [1:0] md, input logic [31:0] k);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    s_tvalid = 1'b1; s_tdata = d; s_tkeep = kp; s_tlast = l;
    ctrl_mode = md; ctrl_constant = k;
    while (!acc && n < 500) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      n++;
    end
    s_tvalid = 1'b0;
    check("send_accept", acc, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int          base_acc, base_emit, idx;
    logic        a;
    logic [63:0] d;
    rst_n = 1'b0; rnd_ready_en = 1'b0; m_tready_dir = 1'b1;
    s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
    ctrl_mode = 2'd0; ctrl_constant = '0;

    #2;
    check("rst_tready", s_tready, 0);
    check("rst_mvalid", m_tvalid, 0);
    check("rst_pkt", pkt_count, 0);
    check("rst_sat", sat_flag, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 check("tready_pre_edge", s_tready, 0);
    @(posedge clk);
    #1 check("tready_post_edge", s_tready, 1);

    // Wrap add with first-beat latency.
    send_beat(64'h00000005_FFFFFFFF, 8'hFF, 1'b0, 2'd0, 32'd1);
    check("lat_n0", m_tvalid, 0);
    @(posedge clk); #1 check("lat_n1", m_tvalid, 0);
    @(posedge clk); #1 check("lat_n2", m_tvalid, 0);
    @(posedge clk); #1 check("lat_n3", m_tvalid, 1);
    for (int i = 0; i < 3; i++) send_beat(64'h00000005_FFFFFFFF, 8'hFF, i == 2, 2'd0, 32'd1);
    drain();
    check("add_data", last_emit_data, 64'h00000006_00000000);
    check("add_pkt", pkt_count, 1);
    check("add_sat", sat_flag, 0);

    // Saturation, masked lane, stickiness.
    send_beat(64'h00000001_FFFFFFF8, 8'hF0, 1'b1, 2'd2, 32'h10);
    drain();
    check("sat_masked_data", last_emit_data, 64'h00000011_FFFFFFF8);
    check("sat_masked_flag", sat_flag, 0);
    send_beat(64'h00000001_FFFFFFF8, 8'hFF, 1'b1, 2'd2, 32'h10);
    drain();
    check("sat_data", last_emit_data, 64'h00000011_FFFFFFFF);
    check("sat_flag", sat_flag, 1);
    send_beat(64'h0, 8'hFF, 1'b1, 2'd0, 32'd0);
    drain();
    check("sat_sticky", sat_flag, 1);
    check("pkt_after_sat", pkt_count, 4);

    // Mid-packet control change is ignored.
    send_beat(64'h0000000A_0000000A, 8'hFF, 1'b0, 2'd0, 32'd2);
    send_beat(64'h0000000A_0000000A, 8'hFF, 1'b0, 2'd1, 32'd7);
    send_beat(64'h0000000A_0000000A, 8'hFF, 1'b1, 2'd1, 32'd7);
    drain();
    check("op_held", last_emit_data, 64'h0000000C_0000000C);
    send_beat(64'h00000000_00000002, 8'hFF, 1'b1, 2'd1, 32'd3);
    drain();
    check("sub_wrap", last_emit_data, 64'hFFFFFFFD_FFFFFFFF);

    // Backpressure fills exactly DEPTH credits.
    m_tready_dir = 1'b0;
    base_acc = acc_cnt; base_emit = emit_cnt; idx = 0;
    ctrl_mode = 2'd0; ctrl_constant = 32'd1; s_tkeep = 8'hFF;
    s_tdata = {32'(idx), ~32'(idx)}; s_tlast = 1'b0; s_tvalid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      a = s_tready;
      @(posedge clk);
      #1;
      if (a) begin
        idx++;
        s_tdata = {32'(idx), ~32'(idx)};
        s_tlast = (idx % 4) == 3;
      end
    end
    check("stall_accepts", acc_cnt - base_acc, DEPTH);
    check("stall_tready", s_tready, 0);
    check("stall_mvalid", m_tvalid, 1);
    s_tvalid = 1'b0;
    m_tready_dir = 1'b1;
    drain();
    check("stall_emits", emit_cnt - base_emit, DEPTH);
    check("stall_pkt", pkt_count, exp_pkts);

    // Random valid/ready traffic.
    rnd_ready_en = 1'b1;
    for (int b = 0; b < 1000; b++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      d = {$urandom, $urandom};
      send_beat(d, 8'($urandom), $urandom_range(0, 3) == 0, 2'($urandom), $urandom);
    end
    send_beat(64'h0, 8'hFF, 1'b1, 2'd3, 32'd0);
    rnd_ready_en = 1'b0;
    drain();
    check("rnd_sat", sat_flag, exp_sat);
    check("rnd_pkt", pkt_count, exp_pkts);
    check("rnd_balance", acc_cnt - emit_cnt, 0);
    check("max_credit", max_out, DEPTH);
    check("stall_stable", stall_viol, 0);

    // Asynchronous reset mid-packet.
    send_beat(64'h00000001_00000001, 8'hFF, 1'b0, 2'd0, 32'd5);
    send_beat(64'h00000001_00000001, 8'hFF, 1'b0, 2'd0, 32'd5);
    m_tready_dir = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("pre_rst_mvalid", m_tvalid, 1);
    rst_n = 1'b0;
    #1;
    check("arst_tready", s_tready, 0);
    check("arst_mvalid", m_tvalid, 0);
    check("arst_pkt", pkt_count, 0);
    check("arst_sat", sat_flag, 0);
    m_tready_dir = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 check("rel_tready_pre", s_tready, 0);
    @(posedge clk);
    #1 check("rel_tready_post", s_tready, 1);
    send_beat(64'h0, 8'hFF, 1'b1, 2'd1, 32'd1);
    drain();
    check("new_op_data", last_emit_data, 64'hFFFFFFFF_FFFFFFFF);
    check("new_op_pkt", pkt_count, 1);
    check("new_op_sat", sat_flag, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
